// File: rtl/bus_cmd_initiator_pkg.sv
// Shared types and constants for the app-bus command initiator.
package bus_cmd_initiator_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StGap   = 2'd3;

  typedef struct packed {
    logic        write;
    logic [15:0] wdata;
    logic        check;
    logic [15:0] exp_data;
  } cmd_t;

  // Bus addresses are 8 bits and wrap.
  function automatic logic [7:0] offset_addr(input logic [7:0] addr, input logic [7:0] offset);
    return addr + offset;
  endfunction

endpackage

// File: rtl/bus_cmd_initiator_if.sv
// Command, response and app-bus signals of the initiator; master is the initiator side.
interface bus_cmd_initiator_if #(
  parameter int unsigned ERR_CNT_W = 16
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [7:0]           cmd_addr;
  logic [15:0]          cmd_wdata;
  logic                 cmd_check;
  logic [15:0]          cmd_expect;
  logic                 err_clr;
  logic                 write_qualified;
  logic                 read_qualified;
  logic [7:0]           ab;
  logic [15:0]          db_out;
  logic [15:0]          db_in;
  logic                 data_avail;
  logic                 rsp_valid;
  logic [15:0]          rsp_data;
  logic                 rsp_err;
  logic                 rsp_mismatch;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_check, cmd_expect, err_clr,
    input  db_in, data_avail,
    output cmd_ready, write_qualified, read_qualified, ab, db_out,
    output rsp_valid, rsp_data, rsp_err, rsp_mismatch, err_count, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_check, cmd_expect, err_clr,
    output db_in, data_avail,
    input  cmd_ready, write_qualified, read_qualified, ab, db_out,
    input  rsp_valid, rsp_data, rsp_err, rsp_mismatch, err_count, busy
  );
endinterface

// File: rtl/bus_init_timer.sv
// Loadable 4-bit down-counter with zero flag; times both read latency and idle gap.
module bus_init_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/bus_cmd_initiator.sv
// App-bus initiator: one command -> one strobe -> one response pulse.
// Read-data checking and err_count are built only with BUS_INIT_CHECK_EN defined.
module bus_cmd_initiator
  import bus_cmd_initiator_pkg::*;
#(
  parameter logic [7:0]  ADDR_OFFSET = 8'h00,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned IDLE_GAP    = 1,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input logic                 xclk,
  input logic                 reset,
  bus_cmd_initiator_if.master bus
);

  // Timer counts down to zero, so a phase of N cycles loads N-1.
  localparam logic [3:0] RdLoad  = 4'(RD_LATENCY - 1);
  localparam logic [3:0] GapLoad = 4'(IDLE_GAP - 1);

  logic [1:0]  state_q, state_d;
  cmd_t        cmd_q;
  logic [7:0]  ab_q;
  logic [15:0] db_out_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_data_q;
  logic        rsp_err_q;
  logic        rsp_mismatch_q;

  logic       accept, wr_done, sample, mismatch;
  logic       tmr_load, tmr_zero;
  logic [3:0] tmr_val;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    wr_done  = 1'b0;
    sample   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = 4'd0;
    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (cmd_q.write) begin
          wr_done = 1'b1;
          if (IDLE_GAP == 0) begin
            state_d = StIdle;
          end else begin
            state_d  = StGap;
            tmr_load = 1'b1;
            tmr_val  = GapLoad;
          end
        end else begin
          state_d  = StWait;
          tmr_load = 1'b1;
          tmr_val  = RdLoad;
        end
      end
      StWait: begin
        if (tmr_zero) begin
          sample = 1'b1;
          if (IDLE_GAP == 0) begin
            state_d = StIdle;
          end else begin
            state_d  = StGap;
            tmr_load = 1'b1;
            tmr_val  = GapLoad;
          end
        end
      end
      StGap: begin
        if (tmr_zero) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  bus_init_timer u_timer (
    .clk      (xclk),
    .rst      (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge xclk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      cmd_q          <= '0;
      ab_q           <= 8'h00;
      db_out_q       <= 16'h0000;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= 16'h0000;
      rsp_err_q      <= 1'b0;
      rsp_mismatch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= wr_done | sample;
      if (accept) begin
        cmd_q <= '{write:    bus.cmd_write,
                   wdata:    bus.cmd_wdata,
                   check:    bus.cmd_check,
                   exp_data: bus.cmd_expect};
        ab_q  <= offset_addr(bus.cmd_addr, ADDR_OFFSET);
        if (bus.cmd_write) db_out_q <= bus.cmd_wdata;
      end
      if (wr_done) begin
        rsp_data_q     <= cmd_q.wdata;
        rsp_err_q      <= 1'b0;
        rsp_mismatch_q <= 1'b0;
      end
      if (sample) begin
        rsp_data_q     <= bus.db_in;
        rsp_err_q      <= ~bus.data_avail;
        rsp_mismatch_q <= mismatch;
      end
    end
  end

`ifdef BUS_INIT_CHECK_EN
  logic [ERR_CNT_W-1:0] err_count_q;

  assign mismatch = cmd_q.check & (~bus.data_avail | (bus.db_in != cmd_q.exp_data));

  always_ff @(posedge xclk or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
    end else if (bus.err_clr) begin
      err_count_q <= '0;
    end else if (sample && mismatch && !(&err_count_q)) begin
      err_count_q <= err_count_q + 1'b1;
    end
  end

  assign bus.err_count = err_count_q;
`else
  localparam logic [ERR_CNT_W-1:0] ErrZero = '0;
  logic unused_check;

  assign mismatch      = 1'b0;
  assign bus.err_count = ErrZero;
  assign unused_check  = ^{cmd_q.check, cmd_q.exp_data, bus.cmd_check, bus.cmd_expect,
                           bus.err_clr};
`endif

  assign bus.cmd_ready       = (state_q == StIdle);
  assign bus.busy            = (state_q != StIdle);
  assign bus.write_qualified = (state_q == StIssue) & cmd_q.write;
  assign bus.read_qualified  = (state_q == StIssue) & ~cmd_q.write;
  assign bus.ab              = ab_q;
  assign bus.db_out          = db_out_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.rsp_err         = rsp_err_q;
  assign bus.rsp_mismatch    = rsp_mismatch_q;

endmodule

// File: tb/tb_bus_cmd_initiator.sv
// Directed bench for bus_cmd_initiator with a registered app responder on the main instance.
module tb_bus_cmd_initiator;

`ifdef BUS_INIT_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  bus_cmd_initiator_if #(.ERR_CNT_W(16)) bi  ();
  bus_cmd_initiator_if #(.ERR_CNT_W(16)) bi0 ();
  bus_cmd_initiator_if #(.ERR_CNT_W(16)) bi3 ();

  bus_cmd_initiator u_dut (
    .xclk  (clk),
    .reset (rst),
    .bus   (bi)
  );

  bus_cmd_initiator #(.IDLE_GAP(0)) u_dut_g0 (
    .xclk  (clk),
    .reset (rst),
    .bus   (bi0)
  );

  bus_cmd_initiator #(.ADDR_OFFSET(8'hF8), .IDLE_GAP(3)) u_dut_g3 (
    .xclk  (clk),
    .reset (rst),
    .bus   (bi3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bi0.db_in      = 16'h0000;
  assign bi0.data_avail = 1'b0;
  assign bi3.db_in      = 16'h0000;
  assign bi3.data_avail = 1'b0;

  logic [15:0] wr_reg;

  always @(posedge clk) begin
    if (rst) begin
      wr_reg        <= 16'h0000;
      bi.db_in      <= 16'h0000;
      bi.data_avail <= 1'b0;
    end else begin
      if (bi.write_qualified && bi.ab == 8'h10) wr_reg <= bi.db_out;
      if (bi.read_qualified) begin
        case (bi.ab)
          8'h10, 8'h11: begin bi.db_in <= wr_reg;   bi.data_avail <= 1'b1; end
          8'h12:        begin bi.db_in <= 16'hA5A5; bi.data_avail <= 1'b1; end
          default:      begin bi.db_in <= 16'hFFFF; bi.data_avail <= 1'b0; end
        endcase
      end
    end
  end

  // Offers one command and returns at the negedge of its ISSUE cycle.
  task automatic send(input logic w, input logic [7:0] a, input logic [15:0] d,
                      input logic chk, input logic [15:0] exp_d);
    int waited;
    @(negedge clk);
    bi.cmd_write  = w;
    bi.cmd_addr   = a;
    bi.cmd_wdata  = d;
    bi.cmd_check  = chk;
    bi.cmd_expect = exp_d;
    bi.cmd_valid  = 1'b1;
    waited = 0;
    while (!bi.cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_chk++;
    if (waited >= 20) $display("FAIL send_timeout: cmd_ready never high, addr %h", a);
    else n_pass++;
    @(negedge clk);
    bi.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bi.cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_chk++;
    if (waited >= 20) $display("FAIL idle_timeout: busy after 20 cycles");
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bi.cmd_ready, bi.busy, bi.write_qualified, bi.read_qualified, bi.rsp_valid} !== 5'b10000)
      $display("FAIL reset_ctrl: got %b want 10000",
               {bi.cmd_ready, bi.busy, bi.write_qualified, bi.read_qualified, bi.rsp_valid});
    else n_pass++;
    n_chk++;
    if ({bi.ab, bi.db_out, bi.rsp_data, bi.rsp_err, bi.rsp_mismatch, bi.err_count} !== 58'd0)
      $display("FAIL reset_data: ab %h db_out %h rsp_data %h err_count %h, want all 0",
               bi.ab, bi.db_out, bi.rsp_data, bi.err_count);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_write();
    send(1'b1, 8'h10, 16'h1234, 1'b0, 16'h0000);
    n_chk++;
    if ({bi.write_qualified, bi.read_qualified, bi.cmd_ready, bi.busy, bi.rsp_valid} !== 5'b10010)
      $display("FAIL wr_strobe: got %b want 10010",
               {bi.write_qualified, bi.read_qualified, bi.cmd_ready, bi.busy, bi.rsp_valid});
    else n_pass++;
    n_chk++;
    if (bi.ab !== 8'h10 || bi.db_out !== 16'h1234)
      $display("FAIL wr_bus: ab %h db_out %h, want 10 1234", bi.ab, bi.db_out);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({bi.write_qualified, bi.rsp_valid, bi.rsp_err, bi.rsp_mismatch} !== 4'b0100 ||
        bi.rsp_data !== 16'h1234)
      $display("FAIL wr_rsp: wq/rv/err/mm %b data %h, want 0100 1234",
               {bi.write_qualified, bi.rsp_valid, bi.rsp_err, bi.rsp_mismatch}, bi.rsp_data);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bi.rsp_valid !== 1'b0 || bi.rsp_data !== 16'h1234 || bi.ab !== 8'h10)
      $display("FAIL wr_hold: rv %b data %h ab %h, want 0 1234 10",
               bi.rsp_valid, bi.rsp_data, bi.ab);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_read_back();
    send(1'b0, 8'h11, 16'h0000, 1'b0, 16'h0000);
    n_chk++;
    if ({bi.read_qualified, bi.write_qualified} !== 2'b10 || bi.ab !== 8'h11 ||
        bi.db_out !== 16'h1234)
      $display("FAIL rd_strobe: rq/wq %b ab %h db_out %h, want 10 11 1234",
               {bi.read_qualified, bi.write_qualified}, bi.ab, bi.db_out);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({bi.read_qualified, bi.rsp_valid, bi.busy} !== 3'b001)
      $display("FAIL rd_wait: rq/rv/busy %b, want 001",
               {bi.read_qualified, bi.rsp_valid, bi.busy});
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({bi.rsp_valid, bi.rsp_err, bi.rsp_mismatch} !== 3'b100 || bi.rsp_data !== 16'h1234)
      $display("FAIL rd_rsp: rv/err/mm %b data %h, want 100 1234",
               {bi.rsp_valid, bi.rsp_err, bi.rsp_mismatch}, bi.rsp_data);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_read_err();
    send(1'b0, 8'h7F, 16'h0000, 1'b0, 16'h0000);
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bi.rsp_valid, bi.rsp_err, bi.rsp_mismatch} !== 3'b110 || bi.rsp_data !== 16'hFFFF ||
        bi.err_count !== 16'd0)
      $display("FAIL rderr_unchecked: rv/err/mm %b data %h cnt %0d, want 110 ffff 0",
               {bi.rsp_valid, bi.rsp_err, bi.rsp_mismatch}, bi.rsp_data, bi.err_count);
    else n_pass++;
    wait_idle();
    send(1'b0, 8'h7F, 16'h0000, 1'b1, 16'h0000);
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bi.rsp_valid, bi.rsp_err, bi.rsp_mismatch} !== {2'b11, ChkEn} ||
        bi.err_count !== 16'(ChkEn))
      $display("FAIL rderr_checked: rv/err/mm %b cnt %0d, want 11%b %0d",
               {bi.rsp_valid, bi.rsp_err, bi.rsp_mismatch}, bi.err_count, ChkEn, ChkEn);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_mismatch();
    send(1'b0, 8'h12, 16'h0000, 1'b1, 16'h5A5A);
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bi.rsp_valid, bi.rsp_err, bi.rsp_mismatch} !== {2'b10, ChkEn} ||
        bi.rsp_data !== 16'hA5A5 || bi.err_count !== (ChkEn ? 16'd2 : 16'd0))
      $display("FAIL mm_count: rv/err/mm %b data %h cnt %0d, want 10%b a5a5 %0d",
               {bi.rsp_valid, bi.rsp_err, bi.rsp_mismatch}, bi.rsp_data, bi.err_count,
               ChkEn, ChkEn ? 2 : 0);
    else n_pass++;
    wait_idle();
    send(1'b0, 8'h12, 16'h0000, 1'b1, 16'h5A5A);
    @(negedge clk);
    bi.err_clr = 1'b1;
    @(negedge clk);
    bi.err_clr = 1'b0;
    n_chk++;
    if (bi.rsp_mismatch !== ChkEn || bi.err_count !== 16'd0)
      $display("FAIL mm_clr_priority: mm %b cnt %0d, want %b 0",
               bi.rsp_mismatch, bi.err_count, ChkEn);
    else n_pass++;
    wait_idle();
    send(1'b0, 8'h12, 16'h0000, 1'b1, 16'hA5A5);
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bi.rsp_valid, bi.rsp_mismatch} !== 2'b10 || bi.err_count !== 16'd0)
      $display("FAIL mm_match: rv/mm %b cnt %0d, want 10 0",
               {bi.rsp_valid, bi.rsp_mismatch}, bi.err_count);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int t0[4];
    int t3[4];
    int n0, n3, adj;
    logic prev0, prev3;
    logic [7:0] ab3;
    n0 = 0; n3 = 0; adj = 0; prev0 = 1'b0; prev3 = 1'b0; ab3 = 8'h00;
    @(negedge clk);
    bi0.cmd_write = 1'b1; bi0.cmd_addr = 8'h20; bi0.cmd_wdata = 16'h0001; bi0.cmd_valid = 1'b1;
    bi3.cmd_write = 1'b1; bi3.cmd_addr = 8'h10; bi3.cmd_wdata = 16'h0002; bi3.cmd_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bi0.write_qualified) begin
        if (prev0) adj++;
        if (n0 < 4) t0[n0] = i;
        n0++;
      end
      if (bi3.write_qualified) begin
        if (prev3) adj++;
        if (n3 < 4) t3[n3] = i;
        if (n3 == 0) ab3 = bi3.ab;
        n3++;
      end
      prev0 = bi0.write_qualified;
      prev3 = bi3.write_qualified;
    end
    bi0.cmd_valid = 1'b0;
    bi3.cmd_valid = 1'b0;
    n_chk++;
    if (n0 < 3 || t0[1] - t0[0] != 2 || t0[2] - t0[1] != 2)
      $display("FAIL b2b_gap0: strobes %0d spacing %0d %0d, want >=3 2 2",
               n0, t0[1] - t0[0], t0[2] - t0[1]);
    else n_pass++;
    n_chk++;
    if (n3 < 3 || t3[1] - t3[0] != 5 || t3[2] - t3[1] != 5)
      $display("FAIL b2b_gap3: strobes %0d spacing %0d %0d, want >=3 5 5",
               n3, t3[1] - t3[0], t3[2] - t3[1]);
    else n_pass++;
    n_chk++;
    if (adj != 0) $display("FAIL b2b_adjacent: %0d adjacent strobes, want 0", adj);
    else n_pass++;
    n_chk++;
    if (ab3 !== 8'h08) $display("FAIL addr_offset: ab %h want 08", ab3);
    else n_pass++;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int rsp_seen;
    send(1'b0, 8'h12, 16'h0000, 1'b0, 16'h0000);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({bi.read_qualified, bi.cmd_ready, bi.busy} !== 3'b010)
      $display("FAIL rst_issue: rq/ready/busy %b, want 010",
               {bi.read_qualified, bi.cmd_ready, bi.busy});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    send(1'b0, 8'h12, 16'h0000, 1'b0, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({bi.rsp_valid, bi.cmd_ready, bi.busy} !== 3'b010)
      $display("FAIL rst_wait: rv/ready/busy %b, want 010", {bi.rsp_valid, bi.cmd_ready, bi.busy});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    rsp_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bi.rsp_valid || bi.read_qualified || bi.write_qualified) rsp_seen++;
    end
    n_chk++;
    if (rsp_seen != 0) $display("FAIL rst_dropped: %0d cycles with activity, want 0", rsp_seen);
    else n_pass++;
    send(1'b0, 8'h12, 16'h0000, 1'b0, 16'h0000);
    repeat (2) @(negedge clk);
    n_chk++;
    if (bi.rsp_valid !== 1'b1) $display("FAIL rst_rsp_pre: rv %b want 1", bi.rsp_valid);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++;
    if (bi.rsp_valid !== 1'b0 || bi.rsp_data !== 16'h0000 || bi.cmd_ready !== 1'b1)
      $display("FAIL rst_rsp_async: rv %b data %h ready %b, want 0 0000 1",
               bi.rsp_valid, bi.rsp_data, bi.cmd_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    bi.cmd_valid = 1'b0; bi.cmd_write = 1'b0; bi.cmd_addr = 8'h00; bi.cmd_wdata = 16'h0000;
    bi.cmd_check = 1'b0; bi.cmd_expect = 16'h0000; bi.err_clr = 1'b0;
    bi0.cmd_valid = 1'b0; bi0.cmd_write = 1'b0; bi0.cmd_addr = 8'h00; bi0.cmd_wdata = 16'h0000;
    bi0.cmd_check = 1'b0; bi0.cmd_expect = 16'h0000; bi0.err_clr = 1'b0;
    bi3.cmd_valid = 1'b0; bi3.cmd_write = 1'b0; bi3.cmd_addr = 8'h00; bi3.cmd_wdata = 16'h0000;
    bi3.cmd_check = 1'b0; bi3.cmd_expect = 16'h0000; bi3.err_clr = 1'b0;
    test_reset();
    test_write();
    test_read_back();
    test_read_err();
    test_mismatch();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
